dmem_responder: RTL and testbench

//  Synthesizable data-memory responder: the slave end of the CPU data-memory port
//  (CEN/WEN/OEN active-low, A, D in; Q out). Replaces the behavioural 128x32 SRAM

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the CPU data-memory port.
// Single-port DEPTH x DW word array with a registered read path, a one-pass
// clear sweep after reset, and a side preload port with a valid/ready handshake.
// The CPU port always has priority over the preload port; preloads are only
// offered (ld_ready) while the CPU is idle.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | sweeping zeros through the array, one word per edge
// ST_RUN   | normal operation, CPU accesses and preloads honoured
module dmem_responder #(
    parameter int DEPTH          = 128,
    parameter int AW             = 7,
    parameter int DW             = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CLR_LAST = CW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [DW-1:0] r_mem [DEPTH];
    state_t        r_state;
    logic [CW-1:0] r_clr_cnt;
    logic          r_ready;
    logic [DW-1:0] r_q;

    logic          w_cpu_en;
    logic          w_cpu_wr;
    logic          w_cpu_rd;
    logic          w_a_ok;
    logic          w_ld_ok;
    logic          w_ld_rdy;
    logic          w_ld_fire;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    // r_ready is the registered "accesses honoured" flag. It is only set while
    // in ST_RUN, so gating on it also keeps every access out of the clear
    // sweep and out of the first cycle after reset.
    assign w_cpu_en  = r_ready & ~CEN;
    assign w_cpu_wr  = w_cpu_en & ~WEN;
    assign w_cpu_rd  = w_cpu_en & WEN;
    assign w_a_ok    = ({1'b0, A} < DEPTH_W);
    assign w_ld_ok   = ({1'b0, ld_addr} < DEPTH_W);
    assign w_ld_rdy  = r_ready & CEN;
    assign w_ld_fire = ld_valid & w_ld_rdy;

    assign ready    = r_ready;
    assign ld_ready = w_ld_rdy;
    assign Q        = OEN ? '0 : r_q;

    // Pick the single array write for this edge: clear sweep, CPU, or preload.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = AW'(r_clr_cnt);
                w_wdata = '0;
            end else if (w_cpu_wr) begin
                w_we    = w_a_ok;
                w_waddr = A;
                w_wdata = D;
            end else if (w_ld_fire) begin
                w_we    = w_ld_ok;
                w_waddr = ld_addr;
                w_wdata = ld_data;
            end
        end
    end

    // Array write port; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read data; out-of-range reads return zero, q holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (w_cpu_rd) begin
            r_q <= w_a_ok ? r_mem[A] : '0;
        end
    end

    // Clear/run sequencing with a registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= RST_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 128-deep instance with the clear sweep and a
// 100-deep instance without it (exercises out-of-range addresses), both on
// the same stimulus, checked against an array-level model of the port rules.
module tb_dmem_responder;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, CEN, WEN, OEN, ld_valid;
    logic [AW-1:0] A, ld_addr;
    logic [DW-1:0] D, ld_data;
    logic [DW-1:0] Q, Q1;
    logic          ready, ready1, ld_ready, ld_ready1;

    int n_pass = 0;
    int n_chk  = 0;

    // models: m_* for the 128-deep cleared instance, m1_* for the 100-deep one
    logic [DW-1:0] m_mem [128];
    logic          m_ready = 1'b0;
    int            m_edges = 0;
    logic [DW-1:0] m_q = '0;
    logic [DW-1:0] m1_mem [128];
    bit            m1_known [128];
    logic          m1_ready = 1'b0;
    logic [DW-1:0] m1_q = '0;
    bit            m1_qk = 1'b1;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(128), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
        .Q(Q), .ready(ready), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ready(ld_ready)
    );

    dmem_responder #(.DEPTH(100), .AW(AW), .DW(DW), .CLEAR_ON_RESET(0)) dut1 (
        .clk(clk), .rst(rst), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
        .Q(Q1), .ready(ready1), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ready(ld_ready1)
    );

    // Apply this edge's effect to the models, then advance to just after the edge.
    task automatic tick();
        if (rst) begin
            m_ready  = 1'b0; m_edges = 0; m_q = '0;
            m1_ready = 1'b0; m1_q = '0; m1_qk = 1'b1;
        end else begin
            if (!m_ready) begin
                m_mem[m_edges] = '0;
                m_edges++;
                if (m_edges == 128) m_ready = 1'b1;
            end else if (!CEN) begin
                if (!WEN) m_mem[A] = D;
                else      m_q = m_mem[A];
            end else if (ld_valid) begin
                m_mem[ld_addr] = ld_data;
            end
            if (m1_ready) begin
                if (!CEN) begin
                    if (!WEN) begin
                        if (A < 100) begin m1_mem[A] = D; m1_known[A] = 1'b1; end
                    end else if (A < 100) begin
                        m1_q = m1_mem[A]; m1_qk = m1_known[A];
                    end else begin
                        m1_q = '0; m1_qk = 1'b1;
                    end
                end else if (ld_valid && ld_addr < 100) begin
                    m1_mem[ld_addr] = ld_data; m1_known[ld_addr] = 1'b1;
                end
            end
            m1_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit early;
        rst = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b0; A = '0; D = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        n_chk++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else n_pass++;
        n_chk++; if (Q !== 32'd0) $display("FAIL reset_q got %h exp 0", Q); else n_pass++;
        n_chk++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b exp 0", ld_ready); else n_pass++;
        n_chk++; if (ready1 !== 1'b0) $display("FAIL reset_ready1 got %b exp 0", ready1); else n_pass++;
        rst = 1'b0;
        early = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (i < 128 && ready !== 1'b0) early = 1'b1;
            if (i == 1) begin
                n_chk++; if (ready1 !== 1'b1) $display("FAIL noclear_ready1 got %b exp 1", ready1); else n_pass++;
            end
        end
        n_chk++; if (early) $display("FAIL clear_ready_early got 1 before edge 128 exp 0"); else n_pass++;
        n_chk++; if (ready !== 1'b1) $display("FAIL clear_ready_128 got %b exp 1", ready); else n_pass++;
        CEN = 1'b0; WEN = 1'b1; A = 7'd5;
        tick();
        CEN = 1'b1;
        n_chk++; if (Q !== 32'd0) $display("FAIL cleared_read5 got %h exp 0", Q); else n_pass++;
    endtask

    task automatic test_preload();
        CEN = 1'b1; ld_valid = 1'b1; ld_addr = 7'd0; ld_data = 32'd15;
        #1;
        n_chk++; if (ld_ready !== 1'b1) $display("FAIL preload0_ready got %b exp 1", ld_ready); else n_pass++;
        tick();
        ld_addr = 7'd1; ld_data = 32'd20;
        #1;
        n_chk++; if (ld_ready !== 1'b1) $display("FAIL preload1_ready got %b exp 1", ld_ready); else n_pass++;
        tick();
        ld_valid = 1'b0;
        CEN = 1'b0; WEN = 1'b1; A = 7'd0;
        tick();
        n_chk++; if (Q !== 32'd15) $display("FAIL preload_read0 got %0d exp 15", Q); else n_pass++;
        A = 7'd1;
        tick();
        n_chk++; if (Q !== 32'd20) $display("FAIL preload_read1 got %0d exp 20", Q); else n_pass++;
        CEN = 1'b1;
    endtask

    task automatic test_write();
        CEN = 1'b0; WEN = 1'b0; A = 7'd4; D = 32'd30;
        tick();
        n_chk++; if (Q !== 32'd20) $display("FAIL write_q_hold got %0d exp 20", Q); else n_pass++;
        WEN = 1'b1;
        tick();
        n_chk++; if (Q !== 32'd30) $display("FAIL write_readback got %0d exp 30", Q); else n_pass++;
        CEN = 1'b1;
    endtask

    task automatic test_oen();
        OEN = 1'b1;
        #1;
        n_chk++; if (Q !== 32'd0) $display("FAIL oen_gate got %0d exp 0", Q); else n_pass++;
        OEN = 1'b0;
        #1;
        n_chk++; if (Q !== 32'd30) $display("FAIL oen_restore got %0d exp 30", Q); else n_pass++;
        tick();
        n_chk++; if (Q !== 32'd30) $display("FAIL idle_q_hold got %0d exp 30", Q); else n_pass++;
    endtask

    task automatic test_collision();
        CEN = 1'b0; WEN = 1'b0; A = 7'd2; D = 32'd7;
        ld_valid = 1'b1; ld_addr = 7'd9; ld_data = 32'hDEAD;
        #1;
        n_chk++; if (ld_ready !== 1'b0) $display("FAIL collide_ld_ready got %b exp 0", ld_ready); else n_pass++;
        tick();
        WEN = 1'b1; A = 7'd9;
        tick();
        n_chk++; if (Q !== 32'd0) $display("FAIL collide_mem9_untouched got %h exp 0", Q); else n_pass++;
        CEN = 1'b1;
        #1;
        n_chk++; if (ld_ready !== 1'b1) $display("FAIL collide_accept got %b exp 1", ld_ready); else n_pass++;
        tick();
        ld_valid = 1'b0;
        CEN = 1'b0; WEN = 1'b1; A = 7'd9;
        tick();
        n_chk++; if (Q !== 32'hDEAD) $display("FAIL collide_read9 got %h exp dead", Q); else n_pass++;
        A = 7'd2;
        tick();
        n_chk++; if (Q !== 32'd7) $display("FAIL collide_read2 got %0d exp 7", Q); else n_pass++;
        CEN = 1'b1;
    endtask

    task automatic test_out_of_range();
        CEN = 1'b0; WEN = 1'b0; A = 7'd110; D = 32'h1234;
        tick();
        WEN = 1'b1;
        tick();
        n_chk++; if (Q1 !== 32'd0) $display("FAIL oor_read110 got %h exp 0", Q1); else n_pass++;
        n_chk++; if (Q !== 32'h1234) $display("FAIL full_read110 got %h exp 1234", Q); else n_pass++;
        WEN = 1'b0; A = 7'd99; D = 32'hABCD;
        tick();
        WEN = 1'b1;
        tick();
        n_chk++; if (Q1 !== 32'hABCD) $display("FAIL edge_read99 got %h exp abcd", Q1); else n_pass++;
        CEN = 1'b1; ld_valid = 1'b1; ld_addr = 7'd120; ld_data = 32'd5;
        tick();
        ld_valid = 1'b0;
        CEN = 1'b0; WEN = 1'b1; A = 7'd120;
        tick();
        n_chk++; if (Q1 !== 32'd0) $display("FAIL oor_preload120 got %h exp 0", Q1); else n_pass++;
        n_chk++; if (Q !== 32'd5) $display("FAIL full_preload120 got %h exp 5", Q); else n_pass++;
        CEN = 1'b1;
    endtask

    task automatic test_random();
        bit ld_acc;
        logic [DW-1:0] exp_q;
        ld_acc = 1'b1;
        ld_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!ld_valid || ld_acc) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_addr  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(90, 127))
                                                       : 7'($urandom_range(0, 15));
                ld_data  = $urandom;
            end
            CEN = ($urandom_range(0, 3) == 0);
            WEN = 1'($urandom);
            A   = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(90, 127))
                                              : 7'($urandom_range(0, 15));
            D   = $urandom;
            OEN = ($urandom_range(0, 7) == 0);
            #1;
            n_chk++; if (ld_ready !== (m_ready & CEN)) $display("FAIL rand_ld_ready i=%0d got %b exp %b", i, ld_ready, m_ready & CEN); else n_pass++;
            n_chk++; if (ld_ready1 !== (m1_ready & CEN)) $display("FAIL rand_ld_ready1 i=%0d got %b exp %b", i, ld_ready1, m1_ready & CEN); else n_pass++;
            ld_acc = ld_valid & CEN;
            tick();
            exp_q = OEN ? '0 : m_q;
            n_chk++; if (Q !== exp_q) $display("FAIL rand_q i=%0d got %h exp %h", i, Q, exp_q); else n_pass++;
            if (m1_qk) begin
                exp_q = OEN ? '0 : m1_q;
                n_chk++; if (Q1 !== exp_q) $display("FAIL rand_q1 i=%0d got %h exp %h", i, Q1, exp_q); else n_pass++;
            end
        end
        ld_valid = 1'b0; CEN = 1'b1; OEN = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bit early;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ready !== 1'b0) early = 1'b1;
        end
        rst = 1'b1;
        tick();
        n_chk++; if (ready !== 1'b0 || early) $display("FAIL midclear_ready got %b early=%0d exp 0", ready, early); else n_pass++;
        n_chk++; if (ready1 !== 1'b0) $display("FAIL midclear_ready1 got %b exp 0", ready1); else n_pass++;
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (n == 1) begin
                n_chk++; if (ready1 !== 1'b1) $display("FAIL restart_ready1 got %b exp 1", ready1); else n_pass++;
            end
        end
        n_chk++; if (n != 128) $display("FAIL restart_edges got %0d exp 128", n); else n_pass++;
        n_chk++; if (Q !== 32'd0) $display("FAIL restart_q got %h exp 0", Q); else n_pass++;
        CEN = 1'b0; WEN = 1'b1; A = 7'd4;
        tick();
        CEN = 1'b1;
        n_chk++; if (Q !== 32'd0) $display("FAIL restart_recleared got %h exp 0", Q); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_write();
        test_oen();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
